// File: rtl/alu_seq_ctrl_pkg.sv
// alu_seq_ctrl_pkg
//   Shared definitions for the multi-byte ALU sequencer: 8-bit ALU command
//   codes, the sequencer opcode and FSM state enums, and small op helpers.
package alu_seq_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SHL  = 4'h2;
    localparam logic [3:0] ALU_ASR  = 4'h3;
    localparam logic [3:0] ALU_LSR  = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_XOR  = 4'h7;
    localparam logic [3:0] ALU_RXOR = 4'h8;
    localparam logic [3:0] ALU_NOP  = 4'hF;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_SHL  = 3'd2,
        OP_ASR  = 3'd3,
        OP_LSR  = 3'd4,
        OP_PAR  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    function automatic logic op_is_legal(logic [2:0] op);
        return op <= 3'd5;
    endfunction

    // Right shifts must walk MSB->LSB so the shifted-out bit chains downward.
    function automatic logic op_is_msb_first(seq_op_t op);
        return (op == OP_ASR) || (op == OP_LSR);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if
//   Byte-wide link between the sequencer (master) and one 8-bit ALU (slave).
//   master drives: alu_cmd, alu_inA, alu_inB, alu_sc_i, alu_pari_in
//   slave drives : alu_rslt, alu_sc_o/_en/_clr, alu_pari/_en/_clr
interface alu_seq_ctrl_if;

    logic [3:0] alu_cmd;
    logic [7:0] alu_inA;
    logic [7:0] alu_inB;
    logic       alu_sc_i;
    logic       alu_pari_in;
    logic [7:0] alu_rslt;
    logic       alu_sc_o;
    logic       alu_sc_en;
    logic       alu_sc_clr;
    logic       alu_pari;
    logic       alu_pari_en;
    logic       alu_pari_clr;

    modport master (
        output alu_cmd, alu_inA, alu_inB, alu_sc_i, alu_pari_in,
        input  alu_rslt, alu_sc_o, alu_sc_en, alu_sc_clr,
               alu_pari, alu_pari_en, alu_pari_clr
    );

    modport slave (
        input  alu_cmd, alu_inA, alu_inB, alu_sc_i, alu_pari_in,
        output alu_rslt, alu_sc_o, alu_sc_en, alu_sc_clr,
               alu_pari, alu_pari_en, alu_pari_clr
    );

endinterface

// File: rtl/alu_seq_ctrl_flag_reg.sv
// alu_seq_ctrl_flag_reg
//   Shift-carry and parity registers chained between byte passes.
//   clk, reset     : clock, synchronous active-high reset
//   load           : start accepted; carry <= sc_preset, parity <= 0
//   step           : a byte pass completes this edge; apply ALU flag controls
//   sc_*, pari_*   : ALU flag result with clr-over-en priority
//   sc_q, pari_q   : current register values (fed back to the ALU)
//   sc_d, pari_d   : value the registers take at the coming edge
module alu_seq_ctrl_flag_reg (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic sc_preset,
    input  logic step,
    input  logic sc_o,
    input  logic sc_en,
    input  logic sc_clr,
    input  logic pari,
    input  logic pari_en,
    input  logic pari_clr,
    output logic sc_q,
    output logic pari_q,
    output logic sc_d,
    output logic pari_d
);

    always_comb begin
        sc_d   = sc_q;
        pari_d = pari_q;
        if (load) begin
            sc_d   = sc_preset;
            pari_d = 1'b0;
        end else if (step) begin
            if (sc_clr)        sc_d = 1'b0;
            else if (sc_en)    sc_d = sc_o;
            if (pari_clr)      pari_d = 1'b0;
            else if (pari_en)  pari_d = pari;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sc_q   <= 1'b0;
            pari_q <= 1'b0;
        end else begin
            sc_q   <= sc_d;
            pari_q <= pari_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Multi-byte operation sequencer for one 8-bit ALU. Accepts an NBYTES-wide
//   op, issues one ALU pass per byte, chains carry/parity and assembles the
//   wide result.
//   clk, reset          : clock, synchronous active-high reset
//   start, op, opA, opB : request (accepted only in IDLE) and its operands
//   busy, done, err     : issuing / one-cycle completion / illegal-op pulse
//   result              : wide result, held until the next accepted start
//   carry_out,parity_out: final flag values
//   alu                 : byte-wide ALU link (master side)
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned NBYTES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [8*NBYTES-1:0] opA,
    input  logic [8*NBYTES-1:0] opB,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                parity_out,
    alu_seq_ctrl_if.master      alu
);

    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    seq_state_t               state;
    seq_op_t                  op_q;
    logic [NBYTES-1:0][7:0]   a_q;
    logic [NBYTES-1:0][7:0]   b_q;
    logic [NBYTES-1:0][7:0]   res_q;
    logic [IW-1:0]            idx;

    logic accept, rev, last_byte;
    logic sc_q, pari_q, sc_d, pari_d;

    assign accept    = (state == ST_IDLE) && start;
    assign rev       = op_is_msb_first(op_q);
    assign last_byte = rev ? (idx == '0) : (idx == LAST_IDX);
    assign result    = res_q;

    // Illegal ops also load here: preset is 0 for them, so flags read as 0.
    alu_seq_ctrl_flag_reg u_flags (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .sc_preset(op == OP_SUB),
        .step     (state == ST_STEP),
        .sc_o     (alu.alu_sc_o),
        .sc_en    (alu.alu_sc_en),
        .sc_clr   (alu.alu_sc_clr),
        .pari     (alu.alu_pari),
        .pari_en  (alu.alu_pari_en),
        .pari_clr (alu.alu_pari_clr),
        .sc_q     (sc_q),
        .pari_q   (pari_q),
        .sc_d     (sc_d),
        .pari_d   (pari_d)
    );

    assign alu.alu_sc_i    = sc_q;
    assign alu.alu_pari_in = pari_q;

    always_comb begin
        alu.alu_cmd = ALU_NOP;
        alu.alu_inA = '0;
        alu.alu_inB = '0;
        if (state == ST_STEP) begin
            alu.alu_inA = a_q[idx];
            // Subtract as A + ~B + 1; the +1 is the carry preset at accept.
            alu.alu_inB = (op_q == OP_SUB) ? ~b_q[idx] : b_q[idx];
            case (op_q)
                OP_ADD, OP_SUB: alu.alu_cmd = ALU_ADD;
                OP_SHL:         alu.alu_cmd = ALU_SHL;
                OP_LSR:         alu.alu_cmd = ALU_LSR;
                // Sign fill only on the top byte; lower bytes take the carry.
                OP_ASR:         alu.alu_cmd = (idx == LAST_IDX) ? ALU_ASR : ALU_LSR;
                OP_PAR:         alu.alu_cmd = ALU_RXOR;
                default:        alu.alu_cmd = ALU_NOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            carry_out  <= 1'b0;
            parity_out <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= seq_op_t'(op);
                        a_q  <= opA;
                        b_q  <= opB;
                        if (op_is_legal(op)) begin
                            state <= ST_STEP;
                            busy  <= 1'b1;
                            idx   <= op_is_msb_first(seq_op_t'(op)) ? LAST_IDX : '0;
                        end else begin
                            state      <= ST_ERR;
                            done       <= 1'b1;
                            err        <= 1'b1;
                            res_q      <= '0;
                            carry_out  <= 1'b0;
                            parity_out <= 1'b0;
                        end
                    end
                end
                ST_STEP: begin
                    res_q[idx] <= alu_rslt_byte();
                    if (last_byte) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        carry_out  <= (op_q == OP_PAR) ? 1'b0 : sc_d;
                        parity_out <= pari_d;
                        if (op_q == OP_PAR) begin
                            res_q       <= '0;
                            res_q[0][0] <= pari_d;
                        end
                    end else begin
                        idx <= rev ? idx - 1'b1 : idx + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    function automatic logic [7:0] alu_rslt_byte();
        return alu.alu_rslt;
    endfunction

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Bench for alu_seq_ctrl (NBYTES=2) with a behavioural 8-bit ALU attached
//   on the slave side of the interface.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] opA, opB;
    logic        busy, done, err, carry_out, parity_out;
    logic [15:0] result;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        p;
        logic        e;
    } exp_t;

    exp_t sb[$];

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(.NBYTES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .carry_out (carry_out),
        .parity_out(parity_out),
        .alu       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit ALU
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum          = {1'b0, bus.alu_inA} + {1'b0, bus.alu_inB} + {8'd0, bus.alu_sc_i};
        bus.alu_rslt     = '0;
        bus.alu_sc_o     = 1'b0;
        bus.alu_sc_en    = 1'b0;
        bus.alu_sc_clr   = 1'b0;
        bus.alu_pari     = 1'b0;
        bus.alu_pari_en  = 1'b0;
        bus.alu_pari_clr = 1'b0;
        case (bus.alu_cmd)
            4'h0: begin
                bus.alu_rslt = alu_sum[7:0]; bus.alu_sc_o = alu_sum[8];
                bus.alu_sc_en = 1'b1; bus.alu_pari_clr = 1'b1;
            end
            4'h2: begin
                bus.alu_rslt = {bus.alu_inA[6:0], bus.alu_sc_i}; bus.alu_sc_o = bus.alu_inA[7];
                bus.alu_sc_en = 1'b1; bus.alu_pari_clr = 1'b1;
            end
            4'h3: begin
                bus.alu_rslt = {bus.alu_inA[7], bus.alu_inA[7:1]}; bus.alu_sc_o = bus.alu_inA[0];
                bus.alu_sc_en = 1'b1; bus.alu_pari_clr = 1'b1;
            end
            4'h4: begin
                bus.alu_rslt = {bus.alu_sc_i, bus.alu_inA[7:1]}; bus.alu_sc_o = bus.alu_inA[0];
                bus.alu_sc_en = 1'b1; bus.alu_pari_clr = 1'b1;
            end
            4'h8: begin
                bus.alu_pari = bus.alu_pari_in ^ (^bus.alu_inA);
                bus.alu_pari_en = 1'b1; bus.alu_sc_clr = 1'b1;
            end
            default: ;
        endcase
    end

    // Whole-word reference
    function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [16:0] s;
        e = '0;
        case (o)
            3'd0: begin s = {1'b0, a} + {1'b0, b};          e.res = s[15:0]; e.c = s[16]; end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 17'd1; e.res = s[15:0]; e.c = s[16]; end
            3'd2: begin e.res = {a[14:0], 1'b0};  e.c = a[15]; end
            3'd3: begin e.res = {a[15], a[15:1]}; e.c = a[0];  end
            3'd4: begin e.res = {1'b0, a[15:1]};  e.c = a[0];  end
            3'd5: begin e.p = ^a; e.res = {15'd0, ^a}; end
            default: e.e = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_start(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                               input bit push);
        start = 1'b1; op = o; opA = a; opB = b;
        if (push) sb.push_back(model(o, a, b));
    endtask

    // Entered at the negedge right after the accept edge; returns at the
    // negedge where done is seen (or the bound expires).
    task automatic wait_done(input string tag, input int exp_lat);
        int cyc;
        int nbusy;
        exp_t e;
        cyc = 0; nbusy = 0; e = '0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_busy_cycles"}, nbusy, exp_lat);
        check({tag, "_sb_pending"}, sb.size(), 1);
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, "_result"}, result, e.res);
        check({tag, "_carry"}, carry_out, e.c);
        check({tag, "_parity"}, parity_out, e.p);
        check({tag, "_err"}, err, e.e);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input int lat);
        @(negedge clk);
        drive_start(o, a, b, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, {done, err}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 2'b00);
        check("rst_result", result, 16'h0000);
        check("rst_flags", {carry_out, parity_out}, 2'b00);
        check("rst_alu_cmd", bus.alu_cmd, 4'hF);

        run_op("add_ff_01",   OP_ADD, 16'h00FF, 16'h0001, 2);
        run_op("sub_100_1",   OP_SUB, 16'h0100, 16'h0001, 2);
        run_op("sub_0_1",     OP_SUB, 16'h0000, 16'h0001, 2);
        run_op("shl_8001",    OP_SHL, 16'h8001, 16'h5A5A, 2);
        run_op("asr_8001",    OP_ASR, 16'h8001, 16'h0000, 2);
        run_op("lsr_8001",    OP_LSR, 16'h8001, 16'h0000, 2);
        run_op("par_0301",    OP_PAR, 16'h0301, 16'hFFFF, 2);
        run_op("par_0303",    OP_PAR, 16'h0303, 16'h0000, 2);
        run_op("add_wrap",    OP_ADD, 16'h1234, 16'hEDCC, 2);
        run_op("asr_pos",     OP_ASR, 16'h7F02, 16'h0000, 2);

        // start pulsed during STEP must be ignored
        @(negedge clk);
        drive_start(OP_SHL, 16'h4003, 16'h0000, 1'b1);
        @(negedge clk);
        drive_start(OP_ADD, 16'hFFFF, 16'hFFFF, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("mid_start", 1);
        begin
            int extra;
            extra = 0;
            repeat (5) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check("mid_start_extra_done", extra, 0);
        end

        // start raised during DONE is taken only once back in IDLE
        @(negedge clk);
        drive_start(OP_LSR, 16'h00F1, 16'h0000, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first", 2);
        drive_start(OP_SUB, 16'h0005, 16'h0007, 1'b1);
        @(negedge clk);
        check("b2b_not_in_done", {busy, done}, 2'b00);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", busy, 1);
        wait_done("b2b_second", 2);

        // reset during STEP aborts
        @(negedge clk);
        drive_start(OP_ADD, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("abort_in_step", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy_done_err", {busy, done, err}, 3'b000);
        check("abort_result", result, 16'h0000);
        check("abort_flags", {carry_out, parity_out}, 2'b00);
        check("abort_alu_cmd", bus.alu_cmd, 4'hF);
        begin
            int late;
            late = 0;
            repeat (4) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) late++;
            end
            check("abort_stays_idle", late, 0);
        end

        // illegal op, then a legal op
        run_op("pre_err_sub", OP_SUB, 16'h0000, 16'h0001, 2);
        run_op("illegal_6",   3'd6,   16'hABCD, 16'h1234, 0);
        run_op("illegal_7",   3'd7,   16'h0001, 16'h0001, 0);
        run_op("after_err",   OP_ADD, 16'h00FF, 16'h0001, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
